// File: rtl/apb4_protocol_checker.sv
// ---------------------------------------------------------------------------
// apb4_protocol_checker
//
// Passive APB4 bus monitor. Every APB signal is sampled on the rising edge of
// PCLK. The transfer phase is tracked in an IDLE/SETUP/ACCESS state register.
// Protocol violations are recorded as sticky error flags. Transfer statistics
// are also kept: read and write counts, plus the worst-case wait-state count.
//
// Ports:
//   PCLK, PRESET        bus clock, asynchronous active-high reset
//   PSEL .. PSLVERR     APB4 bus signals, all inputs (PRDATA observed only)
//   err_clr             synchronous clear of err_vec
//   state               tracked phase: 0 IDLE, 1 SETUP, 2 ACCESS
//   err_vec             sticky violation flags (bit meanings at viol below)
//   err_pulse           one-cycle pulse when any err_vec bit newly sets
//   wr_count, rd_count  completed writes / reads, saturating
//   wait_max            largest wait-state count of any completed transfer
// ---------------------------------------------------------------------------
module apb4_protocol_checker #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_LIMIT     = 1023,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR,
    input  logic                    err_clr,
    output logic [1:0]              state,
    output logic [7:0]              err_vec,
    output logic                    err_pulse,
    output logic [CNT_WIDTH-1:0]    wr_count,
    output logic [CNT_WIDTH-1:0]    rd_count,
    output logic [CNT_WIDTH-1:0]    wait_max
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } phase_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = ADDR_WIDTH'(ADDR_LIMIT);
    localparam logic [CNT_WIDTH-1:0]  TIMEOUT_M1 = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONES   = {CNT_WIDTH{1'b1}};

    phase_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    wait_cnt;
    logic                    prev_ready;
    logic                    prev_done;
    logic [ADDR_WIDTH-1:0]   cap_addr;
    logic                    cap_write;
    logic [DATA_WIDTH-1:0]   cap_wdata;
    logic [DATA_WIDTH/8-1:0] cap_strb;
    logic [2:0]              cap_prot;
    logic [7:0]              viol;
    logic                    fields_changed;

    // PRDATA is carried for completeness of the bus view; no check uses it.
    wire s_idle  = !PSEL;
    wire s_setup = PSEL & !PENABLE;
    wire s_acc   = PSEL & PENABLE;
    wire done    = s_acc & PREADY;

    assign state = state_q;

    // The next phase is the current sample class. The one exception is an
    // ACCESS-class sample seen from IDLE: it stays IDLE, so the illegal
    // transfer is flagged rather than tracked.
    always_comb begin
        state_d = IDLE;
        if (s_setup)
            state_d = SETUP;
        else if (s_acc && state_q != IDLE)
            state_d = ACCESS;
    end

    always_comb begin
        fields_changed = (cap_addr != PADDR) || (cap_write != PWRITE) ||
                         (cap_wdata != PWDATA) || (cap_strb != PSTRB) ||
                         (cap_prot != PPROT);
        viol    = 8'h00;
        viol[0] = (state_q == SETUP) && !s_acc;
        viol[1] = PENABLE && !PSEL;
        viol[2] = (s_setup || s_acc) && !PWRITE && (PSTRB != '0);
        viol[3] = (state_q == ACCESS) && !prev_ready && s_acc && fields_changed;
        viol[4] = (state_q == IDLE) && s_acc;
        viol[5] = prev_done && PENABLE;
        viol[6] = done && (PADDR > ADDR_MAX) && !PSLVERR;
        // Flag on the sample whose increment brings wait_cnt up to the limit.
        viol[7] = s_acc && !PREADY && (wait_cnt == TIMEOUT_M1);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= IDLE;
            prev_ready <= 1'b0;
            prev_done  <= 1'b0;
            cap_addr   <= '0;
            cap_write  <= 1'b0;
            cap_wdata  <= '0;
            cap_strb   <= '0;
            cap_prot   <= '0;
        end else begin
            state_q    <= state_d;
            prev_ready <= PREADY;
            prev_done  <= done;
            if (s_setup || s_acc) begin
                cap_addr  <= PADDR;
                cap_write <= PWRITE;
                cap_wdata <= PWDATA;
                cap_strb  <= PSTRB;
                cap_prot  <= PPROT;
            end
        end
    end

    // A violation in the same cycle as err_clr wins. The pulse only fires
    // for bits that were clear before this sample.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            err_vec   <= 8'h00;
            err_pulse <= 1'b0;
        end else begin
            err_vec   <= (err_clr ? 8'h00 : err_vec) | viol;
            err_pulse <= |(viol & ~err_vec);
        end
    end

    // wait_max takes the wait count before this sample clears it.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wait_cnt <= '0;
            wait_max <= '0;
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (s_acc && !PREADY)
                wait_cnt <= (wait_cnt == CNT_ONES) ? wait_cnt : wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (done && wait_cnt > wait_max)
                wait_max <= wait_cnt;
            if (done && PWRITE && wr_count != CNT_ONES)
                wr_count <= wr_count + 1'b1;
            if (done && !PWRITE && rd_count != CNT_ONES)
                rd_count <= rd_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_apb4_protocol_checker.sv
// ---------------------------------------------------------------------------
// tb_apb4_protocol_checker
//
// Directed bench for apb4_protocol_checker. Each step drives one bus sample.
// The bench then waits for the edge that samples it, followed by a settle
// delay, and compares outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_apb4_protocol_checker;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic        PREADY, PSLVERR, err_clr;
    logic [1:0]  state;
    logic [7:0]  err_vec;
    logic        err_pulse;
    logic [15:0] wr_count, rd_count, wait_max;

    int checks = 0;
    int errors = 0;

    apb4_protocol_checker dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .err_clr(err_clr), .state(state), .err_vec(err_vec),
        .err_pulse(err_pulse), .wr_count(wr_count), .rd_count(rd_count),
        .wait_max(wait_max)
    );

    always #5 PCLK = ~PCLK;

    // Drive one bus sample, let it be clocked in, then settle off the edge.
    task automatic applyStimulus(input logic sel, input logic en, input logic wr,
                                 input logic [31:0] addr, input logic [3:0] strb,
                                 input logic ready, input logic slverr,
                                 input logic clr);
        PSEL = sel; PENABLE = en; PWRITE = wr; PADDR = addr; PSTRB = strb;
        PREADY = ready; PSLVERR = slverr; err_clr = clr;
        @(posedge PCLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        PRESET = 1'b1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0;
        PWDATA = 32'hCAFE_0001; PRDATA = 32'h1234_5678; PSTRB = 0; PPROT = 0;
        PREADY = 0; PSLVERR = 0; err_clr = 0;
        repeat (2) @(posedge PCLK);
        #1;
        checkOutput("reset_state", 32'(state), 32'd0);
        checkOutput("reset_err", 32'(err_vec), 32'h00);
        checkOutput("reset_pulse", 32'(err_pulse), 32'd0);
        checkOutput("reset_wr", 32'(wr_count), 32'd0);
        checkOutput("reset_wait", 32'(wait_max), 32'd0);
        PRESET = 1'b0;
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 0, 0, 0);

        // Legal write with two wait states: state 1,2,2,2,0
        applyStimulus(1, 0, 1, 32'h10, 4'hF, 0, 0, 0);
        checkOutput("wr_setup_state", 32'(state), 32'd1);
        applyStimulus(1, 1, 1, 32'h10, 4'hF, 0, 0, 0);
        checkOutput("wr_wait1_state", 32'(state), 32'd2);
        applyStimulus(1, 1, 1, 32'h10, 4'hF, 0, 0, 0);
        checkOutput("wr_wait2_state", 32'(state), 32'd2);
        applyStimulus(1, 1, 1, 32'h10, 4'hF, 1, 0, 0);
        checkOutput("wr_done_state", 32'(state), 32'd2);
        checkOutput("wr_count_1", 32'(wr_count), 32'd1);
        checkOutput("wait_max_2", 32'(wait_max), 32'd2);
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 0, 0, 0);
        checkOutput("wr_idle_state", 32'(state), 32'd0);
        checkOutput("wr_no_err", 32'(err_vec), 32'h00);

        // Read carrying strobes
        applyStimulus(1, 0, 0, 32'h10, 4'h3, 0, 0, 0);
        checkOutput("rd_strb_err", 32'(err_vec), 32'h04);
        checkOutput("rd_strb_pulse", 32'(err_pulse), 32'd1);
        applyStimulus(1, 1, 0, 32'h10, 4'h3, 1, 0, 0);
        checkOutput("rd_strb_pulse_once", 32'(err_pulse), 32'd0);
        checkOutput("rd_count_1", 32'(rd_count), 32'd1);
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 0, 0, 0);

        // Address changes while the slave is stalling
        applyStimulus(1, 0, 1, 32'h10, 4'hF, 0, 0, 0);
        applyStimulus(1, 1, 1, 32'h10, 4'hF, 0, 0, 0);
        applyStimulus(1, 1, 1, 32'h14, 4'hF, 0, 0, 0);
        checkOutput("unstable_err", 32'(err_vec), 32'h0C);
        checkOutput("unstable_pulse", 32'(err_pulse), 32'd1);
        applyStimulus(1, 1, 1, 32'h14, 4'hF, 1, 0, 0);
        checkOutput("wr_count_2", 32'(wr_count), 32'd2);
        checkOutput("wait_max_hold", 32'(wait_max), 32'd2);
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 0, 0, 1);
        checkOutput("clear_err", 32'(err_vec), 32'h00);
        checkOutput("clear_no_pulse", 32'(err_pulse), 32'd0);

        // ACCESS without SETUP
        applyStimulus(1, 1, 1, 32'h10, 4'hF, 0, 0, 0);
        checkOutput("no_setup_err", 32'(err_vec), 32'h10);
        checkOutput("no_setup_state", 32'(state), 32'd0);
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 0, 0, 1);
        checkOutput("clear_err2", 32'(err_vec), 32'h00);

        // Hang detection: 16 wait cycles, then completion
        applyStimulus(1, 0, 1, 32'h20, 4'hF, 0, 0, 0);
        for (int i = 0; i < 15; i++)
            applyStimulus(1, 1, 1, 32'h20, 4'hF, 0, 0, 0);
        checkOutput("timeout_not_yet", 32'(err_vec), 32'h00);
        applyStimulus(1, 1, 1, 32'h20, 4'hF, 0, 0, 0);
        checkOutput("timeout_err", 32'(err_vec), 32'h80);
        checkOutput("timeout_pulse", 32'(err_pulse), 32'd1);
        applyStimulus(1, 1, 1, 32'h20, 4'hF, 1, 0, 0);
        checkOutput("wait_max_16", 32'(wait_max), 32'd16);
        checkOutput("wr_count_3", 32'(wr_count), 32'd3);
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 0, 0, 0);

        // Out-of-range read without, then with, PSLVERR
        applyStimulus(1, 0, 0, 32'h400, 4'h0, 0, 0, 0);
        applyStimulus(1, 1, 0, 32'h400, 4'h0, 1, 0, 0);
        checkOutput("range_err", 32'(err_vec), 32'hC0);
        checkOutput("rd_count_2", 32'(rd_count), 32'd2);
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 0, 0, 1);
        applyStimulus(1, 0, 0, 32'h400, 4'h0, 0, 0, 0);
        applyStimulus(1, 1, 0, 32'h400, 4'h0, 1, 1, 0);
        checkOutput("range_slverr_ok", 32'(err_vec), 32'h00);
        checkOutput("rd_count_3", 32'(rd_count), 32'd3);

        // Back-to-back transfer is legal
        applyStimulus(1, 0, 1, 32'h30, 4'hF, 0, 0, 0);
        checkOutput("b2b_state", 32'(state), 32'd1);
        checkOutput("b2b_no_err", 32'(err_vec), 32'h00);
        applyStimulus(1, 1, 1, 32'h30, 4'hF, 1, 0, 0);
        checkOutput("wr_count_4", 32'(wr_count), 32'd4);

        // PENABLE held after completion
        applyStimulus(1, 1, 1, 32'h30, 4'hF, 1, 0, 0);
        checkOutput("penable_hold_err", 32'(err_vec), 32'h20);
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 0, 0, 1);

        // PENABLE without PSEL
        applyStimulus(0, 1, 0, 32'h0, 4'h0, 0, 0, 0);
        checkOutput("en_no_sel_err", 32'(err_vec), 32'h02);
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 0, 0, 1);

        // SETUP abandoned back to IDLE
        applyStimulus(1, 0, 1, 32'h40, 4'hF, 0, 0, 0);
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 0, 0, 0);
        checkOutput("setup_drop_err", 32'(err_vec), 32'h01);

        // Asynchronous reset in the middle of an ACCESS stall
        applyStimulus(1, 0, 1, 32'h50, 4'hF, 0, 0, 0);
        applyStimulus(1, 1, 1, 32'h50, 4'hF, 0, 0, 0);
        #2 PRESET = 1'b1;
        #1;
        checkOutput("async_rst_state", 32'(state), 32'd0);
        checkOutput("async_rst_err", 32'(err_vec), 32'h00);
        checkOutput("async_rst_wr", 32'(wr_count), 32'd0);
        checkOutput("async_rst_wait", 32'(wait_max), 32'd0);
        @(posedge PCLK);
        #1 PRESET = 1'b0;
        applyStimulus(1, 1, 1, 32'h50, 4'hF, 0, 0, 0);
        checkOutput("post_rst_acc_err", 32'(err_vec), 32'h10);
        checkOutput("post_rst_state", 32'(state), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb4_protocol_checker.md
Name: apb4_protocol_checker

Overview:
Synthesizable, parametrised APB4 bus protocol checker. It passively samples every APB signal at posedge PCLK, tracks the transfer phase in a registered IDLE/SETUP/ACCESS FSM, and flags protocol violations as sticky error bits. It also keeps transfer statistics: read/write counts and the worst-case wait-state count. It sits beside the slave on the bus, so the same checks work in silicon and in simulation.

Parameters:
ADDR_WIDTH, 32, width of PADDR
DATA_WIDTH, 32, width of PWDATA/PRDATA; PSTRB width is DATA_WIDTH/8
ADDR_LIMIT, 1023, highest legal address; a completed access above it must carry PSLVERR
TIMEOUT_CYCLES, 16, consecutive wait cycles (PREADY low in ACCESS) that count as a hang; must be at least 2
CNT_WIDTH, 16, width of the statistics counters

Ports:
PCLK  input  1  bus clock; everything is sampled on its rising edge
PRESET  input  1  asynchronous reset, active-high
PSEL  input  1  APB select
PENABLE  input  1  APB enable
PWRITE  input  1  APB direction
PADDR  input  ADDR_WIDTH  APB address
PWDATA  input  DATA_WIDTH  APB write data
PSTRB  input  DATA_WIDTH/8  APB write strobes
PPROT  input  3  APB protection attributes
PRDATA  input  DATA_WIDTH  APB read data (observed only)
PREADY  input  1  APB ready
PSLVERR  input  1  APB slave error
err_clr  input  1  synchronous clear of err_vec
state  output  2  tracked phase: 0 IDLE, 1 SETUP, 2 ACCESS
err_vec  output  8  sticky violation flags
err_pulse  output  1  one-cycle pulse when any err_vec bit newly sets
wr_count  output  CNT_WIDTH  completed writes, saturating
rd_count  output  CNT_WIDTH  completed reads, saturating
wait_max  output  CNT_WIDTH  largest wait-state count of any completed transfer

Behaviour:
- Reset (PRESET high, asynchronous): state=IDLE; err_vec, err_pulse, counters, wait_max, internal wait_cnt and capture registers all 0.
- Sample classes at each posedge:
  - S_IDLE = !PSEL
  - S_SETUP = PSEL & !PENABLE
  - S_ACC = PSEL & PENABLE
- state register holds the class of the previous sample.
- Completion (done) = S_ACC & PREADY.
- FSM next state:
  - IDLE -> SETUP on S_SETUP; otherwise stays IDLE, including an illegal S_ACC.
  - SETUP -> ACCESS on S_ACC; -> IDLE on S_IDLE; stays SETUP on S_SETUP.
  - ACCESS & !PREADY -> stays ACCESS.
  - ACCESS & done -> IDLE if the next sample is S_IDLE, SETUP if it is S_SETUP.
  - Next state is always the current sample class, except that an S_ACC seen from IDLE maps to IDLE.
- Capture registers: on every S_SETUP sample and every S_ACC sample, latch PADDR, PWRITE, PWDATA, PSTRB and PPROT for the stability check.
- err_vec bits. All are evaluated on the current sample against registered history; set bits hold until err_clr or reset.
  - bit0: state==SETUP and the current sample is not S_ACC (SETUP not followed by ACCESS).
  - bit1: PENABLE & !PSEL.
  - bit2: (S_SETUP | S_ACC) & !PWRITE & PSTRB!=0 (strobe asserted on a read).
  - bit3: state==ACCESS, previous sample had PREADY low, current is S_ACC, and any captured field differs from the current bus value.
  - bit4: state==IDLE & S_ACC (ACCESS entered without SETUP).
  - bit5: previous sample was done and current PENABLE=1 (PENABLE not dropped after completion).
  - bit6: done & PADDR>ADDR_LIMIT & !PSLVERR.
  - bit7: wait_cnt reaches TIMEOUT_CYCLES.
- err_clr: clears all err_vec bits that cycle. A violation detected in the same cycle wins and its bit sets.
- err_pulse: registered; high for exactly one cycle, in the cycle after any bit transitions 0->1. It is not raised for a bit that is already set.
- wait_cnt (internal, CNT_WIDTH):
  - Increments on S_ACC & !PREADY, saturating.
  - Cleared on any other sample.
  - On done, wait_max <= max(wait_max, wait_cnt) using the pre-clear value.
- Counters: wr_count increments on done & PWRITE; rd_count on done & !PWRITE. Both saturate at all-ones with no wrap.
- Back-to-back transfers (done followed directly by S_SETUP) are legal and raise no error.
- Mid-transfer reset: all state is lost. The first post-reset sample is checked against IDLE history, so a bus caught in S_ACC sets bit4.

Test Plan:
- Legal write: PADDR=0x10, PWRITE=1, PSTRB=0xF; SETUP 1 cycle, ACCESS with 2 wait cycles -> err_vec=0, wr_count=1, wait_max=2, state sequence 0,1,2,2,2,0.
- Read with PSTRB=0x3 -> err_vec[2]=1, err_pulse high for 1 cycle, rd_count=1.
- PADDR changes 0x10->0x14 while PREADY is low in ACCESS -> err_vec[3]=1. Then pulse err_clr with no violation present -> err_vec=0.
- PSEL and PENABLE rise together from idle -> err_vec[4]=1, state stays 0.
- PREADY held low for 16 ACCESS cycles (TIMEOUT_CYCLES=16) -> err_vec[7]=1 on the 16th sample. Complete on the next cycle -> wait_max=16.
- Read at PADDR=1024 completes with PSLVERR=0 -> err_vec[6]=1. The same read with PSLVERR=1 -> no error. Assert PRESET mid-ACCESS -> all outputs 0 asynchronously.
